// File: rtl/montacarga_pkg.sv
// -----------------------------------------------------------------------------
// montacarga_pkg
// Shared definitions for the freight-elevator controller and its shaft plant
// model: motor command encodings, plant FSM states, shaft geometry constants
// and a floor-number to tick-position helper.
// -----------------------------------------------------------------------------
package montacarga_pkg;

   localparam int unsigned NUM_FLOORS = 3;
   localparam int unsigned POS_W      = 10;

   // Motor command as seen on {S1, S0}
   typedef enum logic [1:0] {
      CMD_STOP = 2'b00,
      CMD_UP   = 2'b01,
      CMD_DOWN = 2'b10,
      CMD_ILL  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      UP    = 2'b01,
      DOWN  = 2'b10,
      FAULT = 2'b11
   } state_e;

   // Floor 1 sits at position 0; each floor above adds t ticks.
   function automatic logic [POS_W-1:0] floor_to_pos(input int unsigned floor,
                                                     input int unsigned t);
      return POS_W'((floor - 1) * t);
   endfunction

endpackage

// File: rtl/montacarga_planta_if.sv
// -----------------------------------------------------------------------------
// montacarga_planta_if
// Signal bundle between the lift controller (master) and the shaft plant
// (slave).
//   S0, S1    controller -> plant  motor command {S1,S0}
//   enable    controller -> plant  motor power enable
//   FC1..FC3  plant -> controller  floor limit switches
//   pos       plant -> controller  cabin position in ticks (observation)
//   moving    plant -> controller  position changed this cycle
//   fault     plant -> controller  sticky overtravel / illegal-command flag
// -----------------------------------------------------------------------------
interface montacarga_planta_if;
   import montacarga_pkg::*;

   logic             S0;
   logic             S1;
   logic             enable;
   logic             FC1;
   logic             FC2;
   logic             FC3;
   logic [POS_W-1:0] pos;
   logic             moving;
   logic             fault;

   modport master (
      output S0, S1, enable,
      input  FC1, FC2, FC3, pos, moving, fault
   );

   modport slave (
      input  S0, S1, enable,
      output FC1, FC2, FC3, pos, moving, fault
   );

endinterface

// File: rtl/montacarga_fc_decode.sv
// -----------------------------------------------------------------------------
// montacarga_fc_decode
// Combinational position-to-limit-switch decode. Bit n-1 of fc is high when
// pos is exactly at floor n; it is therefore at most one-hot and all zero
// between floors.
//   pos  in   cabin position in ticks
//   fc   out  {FC3, FC2, FC1}
// -----------------------------------------------------------------------------
module montacarga_fc_decode
   import montacarga_pkg::*;
#(
   parameter int unsigned TICKS_PER_FLOOR = 8
) (
   input  logic [POS_W-1:0]      pos,
   output logic [NUM_FLOORS-1:0] fc
);

   for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      localparam logic [POS_W-1:0] FLOOR_POS =
         floor_to_pos(unsigned'(gi + 1), TICKS_PER_FLOOR);
      assign fc[gi] = (pos == FLOOR_POS);
   end

endmodule

// File: rtl/montacarga_planta.sv
// -----------------------------------------------------------------------------
// montacarga_planta
// Synthesizable plant model of the freight-elevator shaft. Integrates cabin
// position from the controller's motor command while enable is high and
// drives the floor limit switches back. Overtravel at either end or an
// illegal command while enabled latches FAULT, which only reset clears.
//   clk    in   system clock
//   reset  in   synchronous active-high reset (cabin snaps to INIT_FLOOR)
//   bus    slave side of montacarga_planta_if (S0/S1/enable in;
//          FC1..FC3/pos/moving/fault out, all registered)
// -----------------------------------------------------------------------------
module montacarga_planta
   import montacarga_pkg::*;
#(
   parameter int unsigned TICKS_PER_FLOOR = 8,
   parameter int unsigned INIT_FLOOR      = 1
) (
   input  logic                clk,
   input  logic                reset,
   montacarga_planta_if.slave  bus
);

   localparam logic [POS_W-1:0]      POS_TOP = floor_to_pos(NUM_FLOORS, TICKS_PER_FLOOR);
   localparam logic [POS_W-1:0]      POS_RST = floor_to_pos(INIT_FLOOR, TICKS_PER_FLOOR);
   localparam logic [NUM_FLOORS-1:0] FC_RST  = NUM_FLOORS'(1) << (INIT_FLOOR - 1);

   state_e                state_q, state_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [NUM_FLOORS-1:0] fc_q, fc_d;
   logic                  moving_q, moving_d;
   logic                  fault_q, fault_d;

   logic [NUM_FLOORS-1:0] fc_next;
   cmd_e                  cmd;

   assign cmd = cmd_e'({bus.S1, bus.S0});

   // Switches decode the next position so they register on the same edge as
   // pos and can never disagree with it.
   montacarga_fc_decode #(
      .TICKS_PER_FLOOR (TICKS_PER_FLOOR)
   ) u_fc_decode (
      .pos (pos_d),
      .fc  (fc_next)
   );

   // Next-state / next-position logic
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      fault_d = fault_q;

      if (state_q != FAULT) begin
         if (!bus.enable) begin
            // Unpowered motor: every command, including the illegal one, is ignored
            state_d = IDLE;
         end else begin
            unique case (cmd)
               CMD_STOP: state_d = IDLE;
               CMD_UP: begin
                  if (pos_q < POS_TOP) begin
                     pos_d   = pos_q + 1'b1;
                     state_d = UP;
                  end else begin
                     state_d = FAULT;
                     fault_d = 1'b1;
                  end
               end
               CMD_DOWN: begin
                  if (pos_q != '0) begin
                     pos_d   = pos_q - 1'b1;
                     state_d = DOWN;
                  end else begin
                     state_d = FAULT;
                     fault_d = 1'b1;
                  end
               end
               default: begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            endcase
         end
      end
   end

   // In FAULT the switches keep whatever they showed when the fault latched
   always_comb begin
      fc_d     = (state_q == FAULT) ? fc_q : fc_next;
      moving_d = (pos_d != pos_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pos_q    <= POS_RST;
         fc_q     <= FC_RST;
         moving_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         fc_q     <= fc_d;
         moving_q <= moving_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.pos    = pos_q;
   assign bus.FC1    = fc_q[0];
   assign bus.FC2    = fc_q[1];
   assign bus.FC3    = fc_q[2];
   assign bus.moving = moving_q;
   assign bus.fault  = fault_q;

endmodule

// File: tb/tb_montacarga_planta.sv
// -----------------------------------------------------------------------------
// tb_montacarga_planta
// Directed bench for montacarga_planta with T = 4, INIT_FLOOR = 1. A table of
// per-cycle vectors walks through reset, travel, gating, reversal, faults and
// mid-travel reset; short hand-written sequences then measure travel time and
// the width of the floor-2 pulse during a pass.
// -----------------------------------------------------------------------------
module tb_montacarga_planta;
   import montacarga_pkg::*;

   localparam int unsigned T = 4;

   logic clk;
   logic reset;

   montacarga_planta_if bus ();

   montacarga_planta #(
      .TICKS_PER_FLOOR (T),
      .INIT_FLOOR      (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [1:0] cmd;     // {S1,S0}
      logic       en;
      int         pos;
      logic [2:0] fc;      // {FC3,FC2,FC1}
      logic       mv;
      logic       flt;
      state_e     st;
   } vec_t;

   vec_t vecs[$];
   int   total;
   int   passed;

   function automatic vec_t mk(logic r, logic [1:0] c, logic e, int p,
                               logic [2:0] f, logic m, logic fl, state_e s);
      vec_t v;
      v.rst = r; v.cmd = c; v.en = e; v.pos = p;
      v.fc = f; v.mv = m; v.flt = fl; v.st = s;
      return v;
   endfunction

   // Drive on the falling edge, sample 1 time unit after the rising edge
   task automatic step(input logic r, input logic [1:0] c, input logic e);
      @(negedge clk);
      reset      = r;
      bus.S1     = c[1];
      bus.S0     = c[0];
      bus.enable = e;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int fc2_cnt;

      total  = 0;
      passed = 0;
      reset      = 1'b1;
      bus.S0     = 1'b0;
      bus.S1     = 1'b0;
      bus.enable = 1'b0;

      // ---- reset then idle
      vecs.push_back(mk(1, 2'b00, 0, 0, 3'b001, 0, 0, IDLE));
      vecs.push_back(mk(1, 2'b00, 0, 0, 3'b001, 0, 0, IDLE));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 2'b00, 1, 0, 3'b001, 0, 0, IDLE));
      // ---- up to floor 2, then stop
      vecs.push_back(mk(0, 2'b01, 1, 1, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 2, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 3, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 4, 3'b010, 1, 0, UP));
      vecs.push_back(mk(0, 2'b00, 1, 4, 3'b010, 0, 0, IDLE));
      // ---- continue to floor 3
      vecs.push_back(mk(0, 2'b01, 1, 5, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 6, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 7, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 8, 3'b100, 1, 0, UP));
      // ---- immediate reversal, down to floor 1
      vecs.push_back(mk(0, 2'b10, 1, 7, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 6, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 5, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 4, 3'b010, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 3, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 2, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 1, 3'b000, 1, 0, DOWN));
      vecs.push_back(mk(0, 2'b10, 1, 0, 3'b001, 1, 0, DOWN));
      // ---- enable gating 1,0,1,0 then reversal
      vecs.push_back(mk(0, 2'b01, 1, 1, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 0, 1, 3'b000, 0, 0, IDLE));
      vecs.push_back(mk(0, 2'b01, 1, 2, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 0, 2, 3'b000, 0, 0, IDLE));
      vecs.push_back(mk(0, 2'b10, 1, 1, 3'b000, 1, 0, DOWN));
      // ---- illegal command with motor disabled is ignored
      vecs.push_back(mk(0, 2'b11, 0, 1, 3'b000, 0, 0, IDLE));
      // ---- illegal command mid-shaft at pos 3
      vecs.push_back(mk(0, 2'b01, 1, 2, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 3, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b11, 1, 3, 3'b000, 0, 1, FAULT));
      vecs.push_back(mk(0, 2'b10, 1, 3, 3'b000, 0, 1, FAULT));
      vecs.push_back(mk(1, 2'b00, 0, 0, 3'b001, 0, 0, IDLE));
      // ---- overtravel at the top
      for (int p = 1; p <= 8; p++)
         vecs.push_back(mk(0, 2'b01, 1, p,
                           (p == 4) ? 3'b010 : (p == 8) ? 3'b100 : 3'b000,
                           1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 8, 3'b100, 0, 1, FAULT));
      vecs.push_back(mk(0, 2'b10, 1, 8, 3'b100, 0, 1, FAULT));
      vecs.push_back(mk(0, 2'b00, 0, 8, 3'b100, 0, 1, FAULT));
      vecs.push_back(mk(1, 2'b01, 1, 0, 3'b001, 0, 0, IDLE));
      // ---- overtravel at the bottom
      vecs.push_back(mk(0, 2'b10, 1, 0, 3'b001, 0, 1, FAULT));
      vecs.push_back(mk(1, 2'b00, 0, 0, 3'b001, 0, 0, IDLE));
      // ---- reset mid-travel snaps back to floor 1 without fault
      vecs.push_back(mk(0, 2'b01, 1, 1, 3'b000, 1, 0, UP));
      vecs.push_back(mk(0, 2'b01, 1, 2, 3'b000, 1, 0, UP));
      vecs.push_back(mk(1, 2'b01, 1, 0, 3'b001, 0, 0, IDLE));

      foreach (vecs[i]) begin
         logic [2:0] fc_act;
         step(vecs[i].rst, vecs[i].cmd, vecs[i].en);
         fc_act = {bus.FC3, bus.FC2, bus.FC1};
         total++;
         if (int'(bus.pos) == vecs[i].pos && fc_act === vecs[i].fc &&
             bus.moving === vecs[i].mv && bus.fault === vecs[i].flt &&
             dut.state_q == vecs[i].st) begin
            passed++;
         end else begin
            $display("FAIL vec%0d: got pos=%0d fc=%b moving=%b fault=%b state=%s, expected pos=%0d fc=%b moving=%b fault=%b state=%s",
                     i, bus.pos, fc_act, bus.moving, bus.fault, dut.state_q.name(),
                     vecs[i].pos, vecs[i].fc, vecs[i].mv, vecs[i].flt, vecs[i].st.name());
         end
      end

      // ---- travel time floor 1 -> floor 3 must be exactly 2T cycles
      step(1, 2'b00, 0);
      cyc = 0;
      while (!bus.FC3 && cyc < 40) begin
         step(0, 2'b01, 1);
         cyc++;
      end
      chk("travel_1_to_3_cycles", cyc, 2 * T);
      chk("pos_at_floor3", int'(bus.pos), 2 * T);

      // ---- floor-2 switch must pulse for exactly one cycle on the way down
      fc2_cnt = 0;
      for (int i = 0; i < 2 * T; i++) begin
         step(0, 2'b10, 1);
         if (bus.FC2) fc2_cnt++;
      end
      chk("fc2_pulse_cycles", fc2_cnt, 1);
      chk("fc1_at_bottom", int'(bus.FC1), 1);
      chk("fault_after_round_trip", int'(bus.fault), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
